// File: rtl/gray_decoder_display_n.sv
// ============================================================================
// gray_decoder_display_n
//
// Board-level Gray-code reader. Each debounced press of 'read' samples the
// Gray-coded switch bank. The sample is converted to binary, then to BCD with
// a sequential double-dabble. The binary value goes to the LEDs. The decimal
// value goes to a multiplexed 7-segment display.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   read       in   1        raw push-button, active-high, asynchronous
//   in_switch  in   GRAY_W   raw Gray-code switches, asynchronous
//   led        out  GRAY_W   binary value of the last capture
//   an_n       out  DIGITS   one-hot, active-low digit enables (bit0 = units)
//   seg_n      out  7        active-low segments {g,f,e,d,c,b,a}
//   busy       out  1        conversion in progress
//   valid      out  1        one-cycle pulse when a new value reaches the display
//   ovf        out  1        last capture >= 10**DIGITS (held until next capture)
//
// Configuration
//   LZB_EN  when defined, digits above the most significant non-zero digit
//           are blanked. Digit 0 is never blanked.
// ============================================================================
module gray_decoder_display_n #(
    parameter int GRAY_W       = 4,
    parameter int DIGITS       = 4,
    parameter int DEBOUNCE_CNT = 50000,
    parameter int REFRESH_CNT  = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic [GRAY_W-1:0] in_switch,
    output logic [GRAY_W-1:0] led,
    output logic [DIGITS-1:0] an_n,
    output logic [6:0]        seg_n,
    output logic              busy,
    output logic              valid,
    output logic              ovf
);

    // One spare nibble on top of the displayed digits catches overflow.
    localparam int BCD_W = 4 * DIGITS + 4;
    localparam int DB_W  = $clog2(DEBOUNCE_CNT);
    localparam int RF_W  = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int IX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SC_W  = $clog2(GRAY_W + 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } fsmState_t;

    // Prefix XOR from the MSB down: b[i] = ^g[GRAY_W-1:i].
    function automatic logic [GRAY_W-1:0] grayToBin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // One double-dabble step. The result is {bit shifted out, new BCD}.
    function automatic logic [BCD_W:0] dabbleStep(input logic [BCD_W-1:0] bcd,
                                                  input logic bitIn);
        logic [BCD_W-1:0] adj;
        for (int n = 0; n <= DIGITS; n++) begin
            adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? (bcd[4*n +: 4] + 4'd3)
                                                    : bcd[4*n +: 4];
        end
        return {adj, bitIn};
    endfunction

    function automatic logic nibbleOver9(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int n = 0; n <= DIGITS; n++) begin
            bad = bad | (bcd[4*n +: 4] > 4'd9);
        end
        return bad;
    endfunction

    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic              readS1_r, readS2_r;
    logic [GRAY_W-1:0] swS1_r, swS2_r;
    logic [DB_W-1:0]   dbCnt_r;
    logic              dbLevel_r, dbPrev_r;
    logic              trig_s;

    fsmState_t         state_r;
    logic [GRAY_W-1:0] gray_r, bin_r;
    logic [BCD_W-1:0]  bcd_r;
    logic [SC_W-1:0]   shiftCnt_r;
    logic              ovfAcc_r;
    logic [4*DIGITS-1:0] dispBcd_r;
    logic [BCD_W:0]    step_s;
    logic              ovfNext_s;

    logic [RF_W-1:0]   refCnt_r;
    logic [IX_W-1:0]   digIdx_r;
    logic [3:0]        nibble_s;
    logic [6:0]        segNext_s;

    // Synchronisers and the debounce counter for the button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readS1_r  <= 1'b0;
            readS2_r  <= 1'b0;
            swS1_r    <= '0;
            swS2_r    <= '0;
            dbCnt_r   <= '0;
            dbLevel_r <= 1'b0;
            dbPrev_r  <= 1'b0;
        end else begin
            readS1_r <= read;
            readS2_r <= readS1_r;
            swS1_r   <= in_switch;
            swS2_r   <= swS1_r;
            dbPrev_r <= dbLevel_r;
            if (readS2_r == dbLevel_r) begin
                dbCnt_r <= '0;
            end else if (dbCnt_r == DB_W'(DEBOUNCE_CNT - 1)) begin
                dbLevel_r <= ~dbLevel_r;
                dbCnt_r   <= '0;
            end else begin
                dbCnt_r <= dbCnt_r + DB_W'(1);
            end
        end
    end

    // Only the rising edge of the debounced level starts a capture.
    assign trig_s = dbLevel_r & ~dbPrev_r;

    // Next double-dabble step, and the running overflow flag including it.
    always_comb begin
        step_s    = dabbleStep(bcd_r, bin_r[GRAY_W-1]);
        ovfNext_s = ovfAcc_r | step_s[BCD_W] | (step_s[BCD_W-1 -: 4] != 4'd0);
    end

    // Capture and conversion FSM. The display and ovf update on the same edge
    // that raises valid, so the pulse marks the cycle the new value appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            gray_r     <= '0;
            bin_r      <= '0;
            bcd_r      <= '0;
            shiftCnt_r <= '0;
            ovfAcc_r   <= 1'b0;
            dispBcd_r  <= '0;
            led        <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (trig_s) begin
                        gray_r  <= swS2_r;
                        busy    <= 1'b1;
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    bin_r      <= grayToBin(gray_r);
                    led        <= grayToBin(gray_r);
                    bcd_r      <= '0;
                    shiftCnt_r <= '0;
                    ovfAcc_r   <= 1'b0;
                    state_r    <= SHIFT;
                end
                SHIFT: begin
                    bcd_r      <= step_s[BCD_W-1:0];
                    bin_r      <= {bin_r[GRAY_W-2:0], 1'b0};
                    shiftCnt_r <= shiftCnt_r + SC_W'(1);
                    ovfAcc_r   <= ovfNext_s;
                    if (shiftCnt_r == SC_W'(GRAY_W - 1)) begin
                        dispBcd_r <= step_s[4*DIGITS-1:0];
                        ovf       <= ovfNext_s | nibbleOver9(step_s[BCD_W-1:0]);
                        valid     <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef LZB_EN
    logic [DIGITS-1:0] blankVec_s;
    logic              blank_s;

    // A digit is blank when it and every digit above it are zero (not digit 0).
    always_comb begin
        blankVec_s = '0;
        for (int d = 1; d < DIGITS; d++) begin
            blankVec_s[d] = ((dispBcd_r >> (4 * d)) == '0);
        end
        blank_s = 1'(blankVec_s >> digIdx_r);
    end
`endif

    // Segment pattern for the digit currently being driven.
    always_comb begin
        nibble_s = 4'(dispBcd_r >> {digIdx_r, 2'b00});
        if (ovf) begin
            segNext_s = SEG_DASH;
`ifdef LZB_EN
        end else if (blank_s) begin
            segNext_s = SEG_BLANK;
`endif
        end else begin
            segNext_s = segDecode(nibble_s);
        end
    end

    // Refresh timer, digit scan and the registered anode/segment outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refCnt_r <= '0;
            digIdx_r <= '0;
            an_n     <= '1;
            seg_n    <= SEG_BLANK;
        end else begin
            if (refCnt_r == RF_W'(REFRESH_CNT - 1)) begin
                refCnt_r <= '0;
                digIdx_r <= (digIdx_r == IX_W'(DIGITS - 1)) ? '0 : digIdx_r + IX_W'(1);
            end else begin
                refCnt_r <= refCnt_r + RF_W'(1);
            end
            an_n  <= ~(DIGITS'(1) << digIdx_r);
            seg_n <= segNext_s;
        end
    end

endmodule

// File: tb/tb_gray_decoder_display_n.sv
// Directed bench for gray_decoder_display_n. Instance A uses GRAY_W=4 and
// DIGITS=4. Instance B uses GRAY_W=8 and DIGITS=2. Both instances share the
// clock, the reset and the button.
module tb_gray_decoder_display_n;

    localparam logic [6:0] SEG0  = 7'b1000000;
    localparam logic [6:0] SEG1  = 7'b1111001;
    localparam logic [6:0] SEG2  = 7'b0100100;
    localparam logic [6:0] SEG5  = 7'b0010010;
    localparam logic [6:0] DASH  = 7'b0111111;
`ifdef LZB_EN
    localparam logic [6:0] LZ    = 7'h7F;
`else
    localparam logic [6:0] LZ    = 7'b1000000;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       read;
    logic [3:0] swA;
    logic [7:0] swB;
    logic [3:0] ledA, anA;
    logic [7:0] ledB;
    logic [1:0] anB;
    logic [6:0] segA, segB;
    logic       busyA, validA, ovfA, busyB, validB, ovfB;

    always #5 clk = ~clk;

    gray_decoder_display_n #(.GRAY_W(4), .DIGITS(4), .DEBOUNCE_CNT(4), .REFRESH_CNT(2)) dutA (
        .clk(clk), .rst_n(rst_n), .read(read), .in_switch(swA), .led(ledA),
        .an_n(anA), .seg_n(segA), .busy(busyA), .valid(validA), .ovf(ovfA));

    gray_decoder_display_n #(.GRAY_W(8), .DIGITS(2), .DEBOUNCE_CNT(4), .REFRESH_CNT(2)) dutB (
        .clk(clk), .rst_n(rst_n), .read(read), .in_switch(swB), .led(ledB),
        .an_n(anB), .seg_n(segB), .busy(busyB), .valid(validB), .ovf(ovfB));

    int nCmp = 0;
    int nBad = 0;
    int vA, vB, latA, latB;
    bit bsyA, bsyB;
    logic [6:0] digA [4];
    logic [6:0] digB [2];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Plays pat[c] on 'read' for 60 cycles. Counts the valid pulses and the
    // busy-rise-to-valid latency for each instance. Optionally pulses reset at
    // cycle rstAt.
    task automatic press(input logic [63:0] pat, input int rstAt);
        int bAtA, bAtB;
        bAtA = -1; bAtB = -1;
        vA = 0; vB = 0; latA = -1; latB = -1; bsyA = 1'b0; bsyB = 1'b0;
        for (int c = 0; c < 60; c++) begin
            read = pat[c];
            @(negedge clk);
            if (busyA) begin bsyA = 1'b1; if (bAtA < 0) bAtA = c; end
            if (busyB) begin bsyB = 1'b1; if (bAtB < 0) bAtB = c; end
            if (validA) begin vA++; if (latA < 0) latA = c - bAtA; end
            if (validB) begin vB++; if (latB < 0) latB = c - bAtB; end
            if (c == rstAt)     rst_n = 1'b0;
            if (c == rstAt + 3) rst_n = 1'b1;
        end
        read = 1'b0;
    endtask

    // Records the segment pattern seen while each digit is enabled.
    task automatic scanDigits();
        logic [3:0] selA;
        logic [1:0] selB;
        for (int d = 0; d < 4; d++) digA[d] = 7'h55;
        for (int d = 0; d < 2; d++) digB[d] = 7'h55;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                selA = 4'b0001 << d;
                if (anA == ~selA) digA[d] = segA;
            end
            for (int d = 0; d < 2; d++) begin
                selB = 2'b01 << d;
                if (anB == ~selB) digB[d] = segB;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; read = 1'b0; swA = 4'd0; swB = 8'd0;
        repeat (3) @(negedge clk);
        checkEq("rst ledA", ledA, 4'h0);
        checkEq("rst anA", anA, 4'hF);
        checkEq("rst segA", segA, 7'h7F);
        checkEq("rst busyA", busyA, 1'b0);
        checkEq("rst validA", validA, 1'b0);
        checkEq("rst ovfA", ovfA, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Gray 0011 -> 2 on A; Gray 80 -> 255 on B, which overflows two digits.
        swA = 4'b0011; swB = 8'b1000_0000;
        press(64'h3FF, -1);
        checkEq("cap1 validA count", vA, 1);
        checkEq("cap1 latency A", latA, 5);
        checkEq("cap1 ledA", ledA, 4'b0010);
        checkEq("cap1 validB count", vB, 1);
        checkEq("cap1 latency B", latB, 9);
        checkEq("cap1 ledB", ledB, 8'hFF);
        checkEq("cap1 ovfB", ovfB, 1'b1);
        scanDigits();
        checkEq("cap1 A dig0", digA[0], SEG2);
        checkEq("cap1 A dig1", digA[1], LZ);
        checkEq("cap1 A dig3", digA[3], LZ);
        checkEq("cap1 B dig0", digB[0], DASH);
        checkEq("cap1 B dig1", digB[1], DASH);

        // Gray 1000 -> 15 on A; Gray 00 -> 0 on B, which clears ovf.
        swA = 4'b1000; swB = 8'h00;
        press(64'h3FF, -1);
        checkEq("cap2 ledA", ledA, 4'b1111);
        checkEq("cap2 ovfA", ovfA, 1'b0);
        checkEq("cap2 ledB", ledB, 8'h00);
        checkEq("cap2 ovfB", ovfB, 1'b0);
        scanDigits();
        checkEq("cap2 A dig0", digA[0], SEG5);
        checkEq("cap2 A dig1", digA[1], SEG1);
        checkEq("cap2 A dig2", digA[2], LZ);
        checkEq("cap2 A dig3", digA[3], LZ);
        checkEq("cap2 B dig0", digB[0], SEG0);
        checkEq("cap2 B dig1", digB[1], LZ);

        // A button that bounces every two cycles never debounces.
        swA = 4'b0011;
        press(64'h0000_0033_3333_3333, -1);
        checkEq("bounce validA", vA, 0);
        checkEq("bounce busyA", bsyA, 1'b0);
        checkEq("bounce ledA", ledA, 4'b1111);

        // The second press lands while B is still shifting, so B drops it.
        swA = 4'b1000;
        press(64'h0000_0000_000F_FF0F, -1);
        checkEq("busy drop validB", vB, 1);

        // Asynchronous reset in the middle of a cycle.
        swB = 8'b1000_0000;
        press(64'h3FF, -1);
        checkEq("pre-rst ovfB", ovfB, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkEq("async ledA", ledA, 4'h0);
        checkEq("async anA", anA, 4'hF);
        checkEq("async segA", segA, 7'h7F);
        checkEq("async busyA", busyA, 1'b0);
        checkEq("async ovfB", ovfB, 1'b0);
        checkEq("async ledB", ledB, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset during SHIFT aborts the conversion without a valid pulse.
        swA = 4'b0011;
        press(64'h3FF, 8);
        checkEq("abort validA", vA, 0);
        checkEq("abort validB", vB, 0);
        checkEq("abort ledA", ledA, 4'h0);

        // Fresh capture after the abort.
        swA = 4'b0001;
        press(64'h3FF, -1);
        checkEq("fresh validA", vA, 1);
        checkEq("fresh ledA", ledA, 4'b0001);
        scanDigits();
        checkEq("fresh A dig0", digA[0], SEG1);
        checkEq("fresh A dig1", digA[1], LZ);
        checkEq("fresh A dig2", digA[2], LZ);
        checkEq("fresh A dig3", digA[3], LZ);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
